// File: rtl/vga_sync_receiver_if.sv
// Signal bundle between a VGA sync source/consumer and vga_sync_receiver.
// The receiver takes the slave side; the source and downstream logic take the master side.
interface vga_sync_receiver_if;
  logic        hsync_in;
  logic        vsync_in;
  logic        locked;
  logic        err;
  logic        frame_start;
  logic [11:0] col;
  logic [10:0] row;
  logic        visible;
  logic [11:0] h_total_meas;
  logic [11:0] h_sync_meas;
  logic [10:0] v_total_meas;
  logic [10:0] v_sync_meas;

  modport slave (
    input  hsync_in, vsync_in,
    output locked, err, frame_start, col, row, visible,
    output h_total_meas, h_sync_meas, v_total_meas, v_sync_meas
  );

  modport master (
    output hsync_in, vsync_in,
    input  locked, err, frame_start, col, row, visible,
    input  h_total_meas, h_sync_meas, v_total_meas, v_sync_meas
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA timing recovery: measures incoming active-low syncs, locks onto the configured
// mode after LOCK_FRAMES good frames, and regenerates col/row/visible aligned to the syncs.
module vga_sync_receiver #(
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_SYNC_START = 656,
  parameter int H_VISIBLE    = 640,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC       = 2,
  parameter int V_SYNC_START = 490,
  parameter int V_VISIBLE    = 480,
  parameter int LOCK_FRAMES  = 2
) (
  input logic               pclk,
  input logic               rst,
  vga_sync_receiver_if.slave bus
);

  localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t        state;
  logic          h_s1, h_s2, h_d;
  logic          v_s1, v_s2, v_d;
  logic          hfall, hrise, vfall, vrise;
  logic [11:0]   hper, hlow;
  logic [10:0]   vper, vlow;
  logic [11:0]   h_total_q, h_sync_q;
  logic [10:0]   v_total_q, v_sync_q;
  logic [11:0]   col_q;
  logic [10:0]   row_q;
  logic          line_err;
  logic [GW-1:0] good;
  logic          locked_q, err_q, frame_start_q;

  logic [11:0]   h_total_new;
  logic [10:0]   v_total_new;
  logic          h_bad, frame_ok, timeout;

  assign hfall = h_d & ~h_s2;
  assign hrise = ~h_d & h_s2;
  assign vfall = v_d & ~v_s2;
  assign vrise = ~v_d & v_s2;

  // Saturated measurements stay at all-ones so they can never match a real mode.
  assign h_total_new = (hper == 12'hFFF) ? 12'hFFF : hper + 12'd1;
  assign v_total_new = (hfall && vper != 11'h7FF) ? vper + 11'd1 : vper;

  assign h_bad    = (hfall && h_total_new != 12'(H_TOTAL)) ||
                    (hrise && hlow != 12'(H_SYNC));
  assign frame_ok = (v_total_new == 11'(V_TOTAL)) && (v_sync_q == 11'(V_SYNC)) &&
                    !line_err && !h_bad;
  assign timeout  = ({1'b0, hper} >= 13'(2 * H_TOTAL));

  always_ff @(posedge pclk) begin
    if (rst) begin
      h_s1          <= 1'b1;
      h_s2          <= 1'b1;
      h_d           <= 1'b1;
      v_s1          <= 1'b1;
      v_s2          <= 1'b1;
      v_d           <= 1'b1;
      hper          <= '0;
      hlow          <= '0;
      vper          <= '0;
      vlow          <= '0;
      h_total_q     <= '0;
      h_sync_q      <= '0;
      v_total_q     <= '0;
      v_sync_q      <= '0;
      col_q         <= '0;
      row_q         <= '0;
      line_err      <= 1'b0;
      good          <= '0;
      state         <= SEARCH;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_s1 <= bus.hsync_in;
      h_s2 <= h_s1;
      h_d  <= h_s2;
      v_s1 <= bus.vsync_in;
      v_s2 <= v_s1;
      v_d  <= v_s2;

      frame_start_q <= vfall;

      if (hfall) begin
        hper      <= '0;
        h_total_q <= h_total_new;
      end else if (hper != 12'hFFF) begin
        hper <= hper + 12'd1;
      end

      if (hfall)
        hlow <= 12'd1;
      else if (!h_s2 && hlow != 12'hFFF)
        hlow <= hlow + 12'd1;

      if (hrise)
        h_sync_q <= hlow;

      if (vfall) begin
        vper      <= '0;
        v_total_q <= v_total_new;
      end else if (hfall && vper != 11'h7FF) begin
        vper <= vper + 11'd1;
      end

      // A line edge coinciding with vfall belongs to the old frame, never to the new pulse.
      if (vfall)
        vlow <= '0;
      else if (hfall && !v_s2 && vlow != 11'h7FF)
        vlow <= vlow + 11'd1;

      if (vrise)
        v_sync_q <= vlow;

      if (vfall)
        line_err <= 1'b0;
      else if (h_bad)
        line_err <= 1'b1;

      if (hfall)
        col_q <= 12'(H_SYNC_START);
      else if (col_q == 12'(H_TOTAL - 1))
        col_q <= '0;
      else
        col_q <= col_q + 12'd1;

      if (vfall)
        row_q <= 11'(V_SYNC_START);
      else if (!hfall && col_q == 12'(H_TOTAL - 1))
        row_q <= (row_q == 11'(V_TOTAL - 1)) ? 11'd0 : row_q + 11'd1;

      err_q <= 1'b0;
      if (timeout) begin
        state    <= SEARCH;
        locked_q <= 1'b0;
        good     <= '0;
        err_q    <= (state == LOCKED);
      end else begin
        case (state)
          SEARCH: begin
            if (vfall) begin
              state <= CHECK;
              good  <= '0;
            end
          end
          CHECK: begin
            if (vfall) begin
              if (!frame_ok) begin
                good <= '0;
              end else if (int'(good) + 1 >= LOCK_FRAMES) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                good     <= '0;
              end else begin
                good <= good + 1'b1;
              end
            end
          end
          LOCKED: begin
            if (h_bad || (vfall && !frame_ok)) begin
              state    <= SEARCH;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
            end
          end
          default: begin
            state    <= SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked       = locked_q;
  assign bus.err          = err_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.col          = col_q;
  assign bus.row          = row_q;
  assign bus.visible      = locked_q && (col_q < 12'(H_VISIBLE)) && (row_q < 11'(V_VISIBLE));
  assign bus.h_total_meas = h_total_q;
  assign bus.h_sync_meas  = h_sync_q;
  assign bus.v_total_meas = v_total_q;
  assign bus.v_sync_meas  = v_sync_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a scaled-down 40x20 mode so whole frames stay short.
`timescale 1ns/1ps
module tb_vga_sync_receiver;
  localparam int HT  = 40;
  localparam int HS  = 6;
  localparam int HSS = 30;
  localparam int HV  = 24;
  localparam int VT  = 20;
  localparam int VS  = 2;
  localparam int VSS = 15;
  localparam int VV  = 12;
  localparam int LF  = 2;
  localparam int FR  = HT * VT;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   vs_lines = VS;
  bit   hs_stop = 1'b0;
  int   short_cnt = 0;
  int   last_hfall_cyc = 0;

  vga_sync_receiver_if bus();

  vga_sync_receiver #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_SYNC_START(HSS), .H_VISIBLE(HV),
    .V_TOTAL(VT), .V_SYNC(VS), .V_SYNC_START(VSS), .V_VISIBLE(VV),
    .LOCK_FRAMES(LF)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // Free-running VGA source; hsync is suppressed or a line shortened only at line start.
  initial begin : source
    int src_col, src_row, line_len, short_done;
    bit hs_off;
    src_col = 0; src_row = 0; line_len = HT; short_done = 0; hs_off = 1'b0;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    forever begin
      @(negedge pclk);
      bus.hsync_in = hs_off || !(src_col >= HSS && src_col < HSS + HS);
      bus.vsync_in = !(src_row >= VSS && src_row < VSS + vs_lines);
      if (!hs_off && src_col == HSS) last_hfall_cyc = cyc;
      if (src_col == line_len - 1) begin
        src_col = 0;
        src_row = (src_row == VT - 1) ? 0 : src_row + 1;
        hs_off  = hs_stop;
        if (short_cnt != short_done) begin
          line_len   = HT - 1;
          short_done = short_cnt;
        end else begin
          line_len = HT;
        end
      end else begin
        src_col++;
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse_reset(input int n);
    @(negedge pclk);
    rst = 1'b1;
    repeat (n) @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic wait_frame_start(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.frame_start !== 1'b1 && n < 2 * FR + 50);
    if (bus.frame_start !== 1'b1) begin
      vectors++; miscompares++;
      $display("[TB] FAIL %s_timeout: no frame_start within %0d cycles", tag, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vectors++; if (bus.locked !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_locked: got %0b want 0", bus.locked); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %0b want 0", bus.err); end
    vectors++; if (bus.frame_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_start: got %0b want 0", bus.frame_start); end
    vectors++; if (bus.col !== 12'd0) begin miscompares++; $display("[TB] FAIL reset_col: got %0d want 0", bus.col); end
    vectors++; if (bus.row !== 11'd0) begin miscompares++; $display("[TB] FAIL reset_row: got %0d want 0", bus.row); end
    vectors++; if (bus.visible !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_visible: got %0b want 0", bus.visible); end
    vectors++; if (bus.h_total_meas !== 12'd0) begin miscompares++; $display("[TB] FAIL reset_h_total: got %0d want 0", bus.h_total_meas); end
    vectors++; if (bus.h_sync_meas !== 12'd0) begin miscompares++; $display("[TB] FAIL reset_h_sync: got %0d want 0", bus.h_sync_meas); end
    vectors++; if (bus.v_total_meas !== 11'd0) begin miscompares++; $display("[TB] FAIL reset_v_total: got %0d want 0", bus.v_total_meas); end
    vectors++; if (bus.v_sync_meas !== 11'd0) begin miscompares++; $display("[TB] FAIL reset_v_sync: got %0d want 0", bus.v_sync_meas); end
    @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic test_lock();
    for (int k = 1; k <= 3; k++) begin
      logic exp_l;
      exp_l = (k == 3);
      wait_frame_start("lock");
      vectors++;
      if (bus.locked !== exp_l) begin miscompares++; $display("[TB] FAIL lock_at_vfall%0d: locked=%0b want %0b", k, bus.locked, exp_l); end
    end
    tick();
    vectors++; if (bus.frame_start !== 1'b0) begin miscompares++; $display("[TB] FAIL frame_start_width: got %0b want 0", bus.frame_start); end
    vectors++; if (bus.locked !== 1'b1) begin miscompares++; $display("[TB] FAIL lock_hold: got %0b want 1", bus.locked); end
    vectors++; if (bus.h_total_meas !== 12'(HT)) begin miscompares++; $display("[TB] FAIL meas_h_total: got %0d want %0d", bus.h_total_meas, HT); end
    vectors++; if (bus.h_sync_meas !== 12'(HS)) begin miscompares++; $display("[TB] FAIL meas_h_sync: got %0d want %0d", bus.h_sync_meas, HS); end
    vectors++; if (bus.v_total_meas !== 11'(VT)) begin miscompares++; $display("[TB] FAIL meas_v_total: got %0d want %0d", bus.v_total_meas, VT); end
    vectors++; if (bus.v_sync_meas !== 11'(VS)) begin miscompares++; $display("[TB] FAIL meas_v_sync: got %0d want %0d", bus.v_sync_meas, VS); end
  endtask

  task automatic test_coords();
    int vis_cnt, hits, n;
    vis_cnt = 0; hits = 0; n = 0;
    wait_frame_start("coords");
    vectors++; if (bus.row !== 11'(VSS)) begin miscompares++; $display("[TB] FAIL vfall_row: got %0d want %0d", bus.row, VSS); end
    vectors++; if (bus.col !== 12'd0) begin miscompares++; $display("[TB] FAIL vfall_col: got %0d want 0", bus.col); end
    vectors++; if (bus.visible !== 1'b0) begin miscompares++; $display("[TB] FAIL vfall_visible: got %0b want 0", bus.visible); end
    do begin
      tick();
      n++;
      if (bus.visible === 1'b1) vis_cnt++;
      if (bus.row == 11'd0 && bus.col == 12'd0) begin
        hits++; vectors++;
        if (bus.visible !== 1'b1) begin miscompares++; $display("[TB] FAIL vis_origin: got %0b want 1", bus.visible); end
      end
      if (bus.row == 11'(VV - 1) && bus.col == 12'(HV - 1)) begin
        hits++; vectors++;
        if (bus.visible !== 1'b1) begin miscompares++; $display("[TB] FAIL vis_last: got %0b want 1", bus.visible); end
      end
      if (bus.row == 11'd0 && bus.col == 12'(HV)) begin
        hits++; vectors++;
        if (bus.visible !== 1'b0) begin miscompares++; $display("[TB] FAIL vis_col_edge: got %0b want 0", bus.visible); end
      end
      if (bus.row == 11'(VV) && bus.col == 12'd0) begin
        hits++; vectors++;
        if (bus.visible !== 1'b0) begin miscompares++; $display("[TB] FAIL vis_row_edge: got %0b want 0", bus.visible); end
      end
    end while (bus.frame_start !== 1'b1 && n < 2 * FR);
    vectors++; if (hits != 4) begin miscompares++; $display("[TB] FAIL coord_points: got %0d want 4", hits); end
    vectors++; if (vis_cnt != HV * VV) begin miscompares++; $display("[TB] FAIL visible_count: got %0d want %0d", vis_cnt, HV * VV); end
  endtask

  task automatic test_short_line();
    int err_cnt;
    logic [11:0] meas;
    logic lk;
    err_cnt = 0; meas = '0; lk = 1'b1;
    wait_frame_start("short");
    repeat (100) tick();
    short_cnt++;
    for (int i = 0; i < 4 * HT; i++) begin
      tick();
      if (bus.err === 1'b1) begin
        err_cnt++;
        if (err_cnt == 1) begin meas = bus.h_total_meas; lk = bus.locked; end
      end
    end
    vectors++; if (err_cnt != 1) begin miscompares++; $display("[TB] FAIL short_err_pulses: got %0d want 1", err_cnt); end
    vectors++; if (meas !== 12'(HT - 1)) begin miscompares++; $display("[TB] FAIL short_h_total: got %0d want %0d", meas, HT - 1); end
    vectors++; if (lk !== 1'b0) begin miscompares++; $display("[TB] FAIL short_locked: got %0b want 0", lk); end
    for (int k = 1; k <= 3; k++) begin
      logic exp_l;
      exp_l = (k == 3);
      wait_frame_start("relock_short");
      vectors++;
      if (bus.locked !== exp_l) begin miscompares++; $display("[TB] FAIL short_relock_vfall%0d: locked=%0b want %0b", k, bus.locked, exp_l); end
    end
  endtask

  task automatic test_hsync_stop();
    int err_cnt, extra_err, lock_seen, delay, n;
    logic lk;
    err_cnt = 0; extra_err = 0; lock_seen = 0; delay = -1; lk = 1'b1; n = 0;
    wait_frame_start("stop");
    repeat (50) tick();
    hs_stop = 1'b1;
    for (int i = 0; i < 4 * HT; i++) begin
      tick();
      if (bus.err === 1'b1) begin
        err_cnt++;
        if (err_cnt == 1) begin delay = cyc - last_hfall_cyc; lk = bus.locked; end
      end
    end
    vectors++; if (err_cnt != 1) begin miscompares++; $display("[TB] FAIL stop_err_pulses: got %0d want 1", err_cnt); end
    vectors++; if (delay != 2 * HT + 4) begin miscompares++; $display("[TB] FAIL stop_timeout_delay: got %0d want %0d", delay, 2 * HT + 4); end
    vectors++; if (lk !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_locked: got %0b want 0", lk); end
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      if (bus.err === 1'b1) extra_err++;
      if (bus.locked === 1'b1) lock_seen++;
    end
    vectors++; if (extra_err != 0) begin miscompares++; $display("[TB] FAIL stop_extra_err: got %0d want 0", extra_err); end
    vectors++; if (lock_seen != 0) begin miscompares++; $display("[TB] FAIL stop_locked_while_dead: got %0d want 0", lock_seen); end
    hs_stop = 1'b0;
    do begin tick(); n++; end while (bus.locked !== 1'b1 && n < 6 * FR);
    vectors++; if (bus.locked !== 1'b1) begin miscompares++; $display("[TB] FAIL stop_relock: got %0b want 1", bus.locked); end
  endtask

  task automatic test_vsync_wide();
    int lock_seen;
    lock_seen = 0;
    vs_lines = 3;
    pulse_reset(2);
    for (int k = 0; k < 5; k++) begin
      wait_frame_start("wide");
      if (bus.locked === 1'b1) lock_seen++;
    end
    vectors++; if (lock_seen != 0) begin miscompares++; $display("[TB] FAIL wide_locked: got %0d want 0", lock_seen); end
    vectors++; if (bus.v_sync_meas !== 11'd3) begin miscompares++; $display("[TB] FAIL wide_v_sync: got %0d want 3", bus.v_sync_meas); end
    vectors++; if (bus.v_total_meas !== 11'(VT)) begin miscompares++; $display("[TB] FAIL wide_v_total: got %0d want %0d", bus.v_total_meas, VT); end
    vs_lines = VS;
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    pulse_reset(2);
    do begin tick(); n++; end while (bus.locked !== 1'b1 && n < 5 * FR);
    vectors++; if (bus.locked !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_prelock: got %0b want 1", bus.locked); end
    wait_frame_start("mid");
    repeat (100) tick();
    @(negedge pclk);
    rst = 1'b1;
    tick();
    vectors++; if (bus.locked !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_locked: got %0b want 0", bus.locked); end
    vectors++; if (bus.col !== 12'd0) begin miscompares++; $display("[TB] FAIL mid_col: got %0d want 0", bus.col); end
    vectors++; if (bus.row !== 11'd0) begin miscompares++; $display("[TB] FAIL mid_row: got %0d want 0", bus.row); end
    vectors++; if (bus.visible !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_visible: got %0b want 0", bus.visible); end
    vectors++; if (bus.h_total_meas !== 12'd0) begin miscompares++; $display("[TB] FAIL mid_h_total: got %0d want 0", bus.h_total_meas); end
    vectors++; if (bus.v_sync_meas !== 11'd0) begin miscompares++; $display("[TB] FAIL mid_v_sync: got %0d want 0", bus.v_sync_meas); end
    @(negedge pclk);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      logic exp_l;
      exp_l = (k == 3);
      wait_frame_start("mid_relock");
      vectors++;
      if (bus.locked !== exp_l) begin miscompares++; $display("[TB] FAIL mid_relock_vfall%0d: locked=%0b want %0b", k, bus.locked, exp_l); end
    end
  endtask

  initial begin
    $display("[TB] starting vga_sync_receiver bench");
    test_reset();
    test_lock();
    test_coords();
    test_short_line();
    test_hsync_stop();
    test_vsync_wide();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
